mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
// - Initiator for the single-port synchronous RAM (MEM) interface: turns valid/ready
//   read/write requests from the ALU datapath into Enable/WE/RE/address/data strobes.
// - Captures read data and returns one response per request on a valid/ready channel.
// - Sits between the alu8bit result path and the RAM.
// PARAMETERS
// - WORDSIZE    8    data width in bits; matches the RAM word size
// - ADDR_WIDTH  9    address width in bits; 512 words by default
// PORTS
// - clk        in   1           single clock; all state changes on posedge
// - rst_n      in   1           asynchronous, active-low reset
// - req_valid  in   1           request present
// - req_ready  out  1           controller can accept a request
// - req_write  in   1           1 = write, 0 = read
// - req_addr   in   ADDR_WIDTH  target address
// - req_wdata  in   WORDSIZE    write data
// - rsp_valid  out  1           response present
// - rsp_ready  in   1           consumer takes the response
// - rsp_rdata  out  WORDSIZE    read data; 0 for a write response
// - rsp_err    out  1           readback mismatch; only with the macro, else tied 0
// - mem_enable out  1           RAM Enable, active high
// - mem_we     out  1           RAM WE
// - mem_re     out  1           RAM RE
// - mem_addr   out  ADDR_WIDTH  RAM address
// - mem_wdata  out  WORDSIZE    RAM data_in
// - mem_rdata  in   WORDSIZE    RAM data_out; valid the cycle after a read-strobe edge
// - busy       out  1           state != IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state = IDLE; every output = 0 except req_ready = 1.
//   - Strobes drop immediately; a RAM cycle in flight is abandoned.
//   - RAM contents are not touched.
// - Every mem_* output and rsp_* output is driven from a flop; none is combinational.
// - FSM states: IDLE, WRITE, READ, RWAIT, RESP.
// - IDLE: req_ready = 1. On edge E0 with req_valid & req_ready:
//   - latch addr and wdata;
//   - go to WRITE if req_write = 1, else to READ.
// - WRITE, one cycle: enable=1, we=1, re=0; RAM writes at E1.
//   - Then RESP with rsp_rdata = 0 and rsp_err = 0.
// - READ, one cycle: enable=1, re=1, we=0; RAM registers data at E1; go to RWAIT.
// - RWAIT, one cycle: strobes = 0; rsp_rdata <= mem_rdata at E2; go to RESP.
// - RESP: rsp_valid = 1 and rsp_rdata/rsp_err stay stable until rsp_valid & rsp_ready.
//   - On that edge go to IDLE.
// - Latency from accept edge E0 to rsp_valid high:
//   - write: 1 cycle (rsp_valid high after E1);
//   - read: 2 cycles (rsp_valid high after E2).
// - Throughput: req_ready is low in every state except IDLE; one transaction in flight.
//   - Best case: write every 3 cycles, read every 4 cycles.
// - Strobes are never asserted with we = re = 1; enable = 0 whenever we = re = 0.
// - req_valid held high while busy: no accept and no state change.
//   - The request is accepted on the first IDLE edge.
// - Address range: the full range 0 .. 2**ADDR_WIDTH-1 is legal; there is no wrap or check.
// CONFIGURATION
// - MEM_ACCESS_READBACK_EN defined:
//   - WRITE is followed by a VREAD cycle (re=1) and a VWAIT cycle, then RESP.
//   - rsp_rdata = value read back.
//   - rsp_err = 1 if the value read back != latched wdata.
//   - Write latency becomes 3 cycles.
// - MEM_ACCESS_READBACK_EN undefined:
//   - no VREAD/VWAIT states; rsp_err is tied to 0; write latency is 1 cycle.
// TESTING
// - Write 8'hA5 to addr 3, then read addr 3:
//   - write rsp_valid 1 cycle after accept, with rsp_rdata = 0;
//   - read rsp_rdata = 8'hA5, 2 cycles after accept.
// - Boundary: write 8'h3C to addr 511 and 8'hC3 to addr 0; read both back.
//   - Results: 8'h3C and 8'hC3; no aliasing.
// - Back-pressure: hold rsp_ready = 0 for 5 cycles after a read of 8'h5A.
//   - rsp_valid and rsp_rdata = 8'h5A stay stable; req_ready = 0 throughout.
//   - req_ready returns to 1 the cycle after the rsp handshake.
// - Reset mid-read: pull rst_n low during READ.
//   - mem_enable = mem_re = 0, rsp_valid = 0 and req_ready = 1 immediately.
//   - After reset, a fresh read of addr 3 returns 8'hA5.
// - Held request: keep req_valid = 1 with a second request while busy.
//   - Exactly one accept per IDLE visit.
//   - The RAM model sees no overlapping strobes and never sees we = re = 1.
// - With MEM_ACCESS_READBACK_EN: bench RAM model corrupts bit 0 on a write of 8'h0F.
//   - rsp_err = 1, rsp_rdata = 8'h0E, 3 cycles after accept.
//   - A normal write gives rsp_err = 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator for a single-port synchronous RAM.
// Turns valid/ready read/write requests into Enable/WE/RE/address/data
// strobes and returns one response per request on a valid/ready channel.
// Only one transaction is in flight; every mem_* and rsp_* output is a flop.
// Optional feature macro: MEM_ACCESS_READBACK_EN -- each write is verified
// by a readback cycle; a mismatch is reported on rsp_err.
module mem_access_ctrl #(
   parameter int WORDSIZE   = 8,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORDSIZE-1:0]   req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WORDSIZE-1:0]   rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_enable,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORDSIZE-1:0]   mem_wdata,
   input  logic [WORDSIZE-1:0]   mem_rdata,
   output logic                  busy
);

`ifdef MEM_ACCESS_READBACK_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      RWAIT = 3'd3,
      RESP  = 3'd4,
      VREAD = 3'd5,
      VWAIT = 3'd6
   } state_t;

   // Readback check: any difference between stored and intended data is an error.
   function automatic logic readback_mismatch(input logic [WORDSIZE-1:0] got,
                                              input logic [WORDSIZE-1:0] expected);
      return (got != expected);
   endfunction
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      RWAIT = 3'd3,
      RESP  = 3'd4
   } state_t;
`endif

   state_t state_r;

   // Transaction FSM; all outputs are registered alongside the state.
   // mem_addr/mem_wdata double as the latched request fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= {WORDSIZE{1'b0}};
         rsp_err    <= 1'b0;
         mem_enable <= 1'b0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         mem_addr   <= {ADDR_WIDTH{1'b0}};
         mem_wdata  <= {WORDSIZE{1'b0}};
         busy       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid && req_ready) begin
                  mem_addr   <= req_addr;
                  mem_wdata  <= req_wdata;
                  mem_enable <= 1'b1;
                  req_ready  <= 1'b0;
                  busy       <= 1'b1;
                  if (req_write) begin
                     state_r <= WRITE;
                     mem_we  <= 1'b1;
                     mem_re  <= 1'b0;
                  end else begin
                     state_r <= READ;
                     mem_we  <= 1'b0;
                     mem_re  <= 1'b1;
                  end
               end else begin
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            WRITE: begin
`ifdef MEM_ACCESS_READBACK_EN
               // Turn the write strobe straight into a verify read.
               state_r    <= VREAD;
               mem_enable <= 1'b1;
               mem_we     <= 1'b0;
               mem_re     <= 1'b1;
`else
               state_r    <= RESP;
               mem_enable <= 1'b0;
               mem_we     <= 1'b0;
               mem_re     <= 1'b0;
               rsp_valid  <= 1'b1;
               rsp_rdata  <= {WORDSIZE{1'b0}};
               rsp_err    <= 1'b0;
`endif
            end
            READ: begin
               state_r    <= RWAIT;
               mem_enable <= 1'b0;
               mem_we     <= 1'b0;
               mem_re     <= 1'b0;
            end
            RWAIT: begin
               // RAM data_out is valid one cycle after the read strobe edge.
               state_r   <= RESP;
               rsp_valid <= 1'b1;
               rsp_rdata <= mem_rdata;
               rsp_err   <= 1'b0;
            end
`ifdef MEM_ACCESS_READBACK_EN
            VREAD: begin
               state_r    <= VWAIT;
               mem_enable <= 1'b0;
               mem_we     <= 1'b0;
               mem_re     <= 1'b0;
            end
            VWAIT: begin
               state_r   <= RESP;
               rsp_valid <= 1'b1;
               rsp_rdata <= mem_rdata;
               rsp_err   <= readback_mismatch(mem_rdata, mem_wdata);
            end
`endif
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  state_r   <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= {WORDSIZE{1'b0}};
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  rsp_valid <= 1'b1;
               end
            end
            default: begin
               // Unreachable encoding: fall back to a quiet, idle controller.
               state_r    <= IDLE;
               req_ready  <= 1'b1;
               rsp_valid  <= 1'b0;
               rsp_rdata  <= {WORDSIZE{1'b0}};
               rsp_err    <= 1'b0;
               mem_enable <= 1'b0;
               mem_we     <= 1'b0;
               mem_re     <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
